// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: FSM state encoding,
// command width and the ADXL command constants used by requesters.
package spi_pkg;

  localparam int CMD_W = 24;

  // ADXL command words
  localparam logic [CMD_W-1:0] ADXL_SOFT_RESET = 24'h0A1F52;
  localparam logic [7:0]       ADXL_READ       = 8'h0B;
  localparam logic [7:0]       ADXL_WRITE      = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_DONE     = 2'd2,
    ST_GAP_WAIT = 2'd3
  } state_t;

  // Wrap a rotated requester index back into 0..n-1 (i is at most 2n-1).
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin selection. The search starts
// at the index after last_grant and wraps at NUM_REQ-1 back to 0.
module rr_picker
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IW-1:0]      win_idx,
  output logic               win_valid
);

  // First requesting index after last_grant, in rotating order
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_valid && req[wrap_idx(int'(last_grant) + k, NUM_REQ)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(wrap_idx(int'(last_grant) + k, NUM_REQ));
        win_onehot[wrap_idx(int'(last_grant) + k, NUM_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI engine between NUM_REQ requesters.
// Flow: IDLE (pick winner) -> ISSUE (start engine, wait ready) -> DONE
// (release grant) -> GAP_WAIT (GAP forced idle cycles) -> IDLE.
// Optional watchdog on ISSUE enabled by macro SPI_ARBITER_TIMEOUT_EN.
//
// Handshake: spi_start is a level held with a constant spi_cmd from the
// grant until spi_ready is sampled high in ISSUE; that single sample
// completes the transaction (done pulse, rsp_data capture). spi_ready
// outside ISSUE carries no meaning and is ignored.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP            = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [CMD_W-1:0]         rsp_data,
  output logic                     busy,
  output logic                     err,
  output logic                     spi_start,
  output logic [CMD_W-1:0]         spi_cmd,
  input  logic                     spi_ready,
  input  logic [CMD_W-1:0]         spi_data,
  output state_t                   dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state, state_next;
  logic [IW-1:0]      last_grant, win_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [3:0]         gap_cnt;
  logic               timeout_evt;
  logic               grant_load, capture, finish, record_last;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  // Watchdog: counts ISSUE cycles, cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (reset || state != ST_ISSUE) wd_cnt <= '0;
    else                            wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_evt = (state == ST_ISSUE) && !spi_ready &&
                       (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: constant 0 for every legal TIMEOUT_CYCLES value
  assign timeout_evt = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (pick_valid) state_next = ST_ISSUE;
      ST_ISSUE:    if (spi_ready || timeout_evt) state_next = ST_DONE;
      ST_DONE:     state_next = ST_GAP_WAIT;
      ST_GAP_WAIT: if (gap_cnt == 4'(GAP - 1)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Output decode: which registered outputs update this cycle
  always_comb begin
    grant_load  = (state == ST_IDLE) && pick_valid;
    capture     = (state == ST_ISSUE) && spi_ready;
    finish      = (state == ST_ISSUE) && (spi_ready || timeout_evt);
    record_last = (state == ST_DONE);
  end

  // Gap counter: starts at 0 on entry to GAP_WAIT, counts each cycle there
  always_ff @(posedge clk) begin
    if (reset || state != ST_GAP_WAIT) gap_cnt <= '0;
    else                               gap_cnt <= gap_cnt + 1'b1;
  end

  // Registered outputs and grant bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt        <= '0;
      done       <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      spi_start  <= 1'b0;
      spi_cmd    <= '0;
      win_idx    <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      done <= '0;
      err  <= timeout_evt;
      busy <= (state_next != ST_IDLE);
      if (grant_load) begin
        gnt       <= pick_onehot;
        spi_start <= 1'b1;
        spi_cmd   <= cmd[int'(pick_idx)*CMD_W +: CMD_W];
        win_idx   <= pick_idx;
      end
      if (finish) begin
        done      <= gnt;
        gnt       <= '0;
        spi_start <= 1'b0;
      end
      if (capture)     rsp_data   <= spi_data;
      if (record_last) last_grant <= win_idx;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter (default NUM_REQ=4, GAP=2). Table of single
// transactions with hand-derived round-robin winners, then hand-written
// sequences for request drop, stray ready, reset in ISSUE, contention and
// (with SPI_ARBITER_TIMEOUT_EN) the watchdog.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [CMD_W*NUM_REQ-1:0] cmd;
  logic [CMD_W-1:0]         cmds [NUM_REQ];
  logic [NUM_REQ-1:0]       gnt, done;
  logic [CMD_W-1:0]         rsp_data, spi_cmd, spi_data;
  logic                     busy, err, spi_start, spi_ready;
  state_t                   dbg_state;

  logic [CMD_W-1:0]   exp_q [$];
  logic [NUM_REQ-1:0] exp_done_q [$];

  int n_cmp = 0;
  int n_err = 0;

  spi_arbiter #(.NUM_REQ(NUM_REQ), .GAP(GAP), .TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .cmd       (cmd),
    .gnt       (gnt),
    .done      (done),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .err       (err),
    .spi_start (spi_start),
    .spi_cmd   (spi_cmd),
    .spi_ready (spi_ready),
    .spi_data  (spi_data),
    .dbg_state (dbg_state)
  );

  // Clock and command packing
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cmd[CMD_W*i +: CMD_W] = cmds[i];
  end

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] exp_gnt;
    logic [CMD_W-1:0]   data;
    int                 hold;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NUM_REQ-1:0] oh);
    int r = 0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req = '0; spi_ready = 1'b0; spi_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_cmd", 32'(spi_cmd), 0);
    chk("rst_rsp", 32'(rsp_data), 0);
    chk("rst_busy_err", {30'd0, busy, err}, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && dbg_state != ST_IDLE; n++) @(negedge clk);
    chk("wait_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Raise req in IDLE; the grant must be visible after exactly one edge
  task automatic start_txn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] exp_gnt);
    wait_idle();
    req = r;
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(exp_gnt));
    chk("start_hi", 32'(spi_start), 1);
    chk("spi_cmd", 32'(spi_cmd), 32'(cmds[idx_of(exp_gnt)]));
    chk("busy_hi", 32'(busy), 1);
  endtask

  // Engine answers; scoreboard holds the expected done/rsp_data
  task automatic complete_txn(input logic [NUM_REQ-1:0] exp_gnt, input logic [CMD_W-1:0] data);
    spi_ready = 1'b1;
    spi_data  = data;
    exp_q.push_back(data);
    exp_done_q.push_back(exp_gnt);
    @(negedge clk);
    spi_ready = 1'b0;
    if (exp_q.size() > 0) begin
      chk("done", 32'(done), 32'(exp_done_q.pop_front()));
      chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
    end
    chk("release", {30'd0, spi_start, |gnt}, 0);
  endtask

  initial begin
    logic [CMD_W-1:0] saved;
    int low;
    int n;

    cmds[0] = 24'h0B0800;
    for (int i = 1; i < NUM_REQ; i++) cmds[i] = 24'($urandom_range(0, 32'hFFFFFF));

    // Winners from last_grant=3 after reset, re-derived per step
    vecs[0] = '{4'b0001, 4'b0001, 24'h0000A5, 0};
    vecs[1] = '{4'b0110, 4'b0010, 24'h111111, 1};
    vecs[2] = '{4'b1001, 4'b1000, 24'h222222, 2};
    vecs[3] = '{4'b1010, 4'b0010, 24'h333333, 0};
    vecs[4] = '{4'b0011, 4'b0001, 24'h444444, 3};
    vecs[5] = '{4'b0100, 4'b0100, 24'h555555, 1};
    vecs[6] = '{4'b1111, 4'b1000, 24'h666666, 0};
    vecs[7] = '{4'b1111, 4'b0001, 24'h777777, 2};

    do_reset();

    // Stray ready in IDLE is ignored
    spi_ready = 1'b1; spi_data = 24'hABCDEF;
    @(negedge clk);
    spi_ready = 1'b0;
    chk("idle_ready_done", 32'(done), 0);
    chk("idle_ready_rsp", 32'(rsp_data), 0);

    for (int v = 0; v < 8; v++) begin
      start_txn(vecs[v].req, vecs[v].exp_gnt);
      for (int h = 0; h < vecs[v].hold; h++) begin
        @(negedge clk);
        chk("hold_start", 32'(spi_start), 1);
        chk("hold_cmd", 32'(spi_cmd), 32'(cmds[idx_of(vecs[v].exp_gnt)]));
      end
      complete_txn(vecs[v].exp_gnt, vecs[v].data);
      req = '0;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
      chk("gap_state", 32'(dbg_state), 32'(ST_GAP_WAIT));
    end

    // Request drop mid-ISSUE (last_grant=0 -> requester 2)
    start_txn(4'b0100, 4'b0100);
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_start", 32'(spi_start), 1);
    end
    complete_txn(4'b0100, 24'h00C0DE);

    // Stray ready in GAP_WAIT
    saved = rsp_data;
    @(negedge clk);
    chk("stray_pre", 32'(dbg_state), 32'(ST_GAP_WAIT));
    spi_ready = 1'b1; spi_data = 24'h123456;
    @(negedge clk);
    spi_ready = 1'b0;
    chk("stray_done", 32'(done), 0);
    chk("stray_state", 32'(dbg_state), 32'(ST_GAP_WAIT));
    chk("stray_rsp", 32'(rsp_data), 32'(saved));
    @(negedge clk);
    chk("stray_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reset during ISSUE (last_grant=2 -> requester 1 first)
    start_txn(4'b0010, 4'b0010);
    @(negedge clk);
    reset = 1'b1; req = 4'b0011;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_issue_start", 32'(spi_start), 0);
    chk("rst_issue_gnt", 32'(gnt), 0);
    chk("rst_issue_done", 32'(done), 0);
    @(negedge clk);
    chk("rst_regrant", 32'(gnt), 32'(4'b0001));
    chk("rst_regrant_done", 32'(done), 0);
    complete_txn(4'b0001, 24'h0FACE0);
    req = '0;

    // Contention: all requesting; spi_start low run = DONE + GAP + IDLE
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        low = 1;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (spi_start) break;
          low++;
        end
        chk("gap_len", 32'(low), 32'(GAP + 2));
      end
      chk("rr_order", 32'(gnt), 32'(4'b0001 << (k % 4)));
      @(negedge clk);
      complete_txn(4'(4'b0001 << (k % 4)), 24'($urandom_range(0, 32'hFFFFFF)));
    end
    req = '0;

`ifdef SPI_ARBITER_TIMEOUT_EN
    // Watchdog: last_grant=0, only requester 0 asks -> 0 wins
    start_txn(4'b0001, 4'b0001);
    saved = rsp_data;
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycle", 32'(n), 50);
    chk("to_done", 32'(done), 32'(4'b0001));
    chk("to_rsp", 32'(rsp_data), 32'(saved));
    req = '0;
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 0);
`else
    n = 0;
    chk("err_tied", 32'(err), 0);
`endif

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound on run time
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
